rs_sched: RTL and testbench
===========================

Name: rs_sched

Overview:
- Per-reservation-station scheduler. It owns the entry pool of one RS.
- Allocates a free entry for each dispatched uop and pulses the per-entry alloc strobe that loads that entry's source trackers.
- Watches each entry's combined source-ready signal (AND of its trackers' ready outputs) and picks one ready entry per cycle.
- Presents the picked entry to the execution unit through a registered valid/ready issue port, and frees the entry on handshake.

Parameters:
- NUM_ENTRIES, 8, number of RS entries; must be at least 2.
- IDX_W, $clog2(NUM_ENTRIES), entry index width.
- CNT_W, $clog2(NUM_ENTRIES+1), free-count width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- disp_valid_rs0  in  1  dispatch request.
- disp_robid_rs0  in  t_rob_id  robid of the dispatched uop.
- disp_ready_rs0  out  1  a free entry exists and no flush is active.
- e_alloc_rs0  out  NUM_ENTRIES  one-hot alloc strobe to the entry trackers.
- e_srcs_ready_rs1  in  NUM_ENTRIES  per-entry all-sources-ready.
- iss_valid_rs1  out  1  issue slot valid (registered).
- iss_entry_rs1  out  IDX_W  entry being issued.
- iss_robid_rs1  out  t_rob_id  robid of the issuing entry.
- iss_ready_rs1  in  1  execution unit accepts the issue.
- flush  in  1  drop all entries.
- num_free  out  CNT_W  count of FREE entries (registered).

Behaviour:
- Per-entry state machine, type t_rs_ent_st:
  - FREE → VALID on e_alloc_rs0[i].
  - VALID → ISSUING when picked.
  - ISSUING → FREE when iss_valid_rs1 & iss_ready_rs1.
  - flush overrides every transition: all entries go to FREE next cycle.
- Reset (synchronous) forces:
  - all entries FREE;
  - iss_valid_rs1 = 0; iss_entry_rs1 = 0; iss_robid_rs1 = 0;
  - num_free = NUM_ENTRIES;
  - age state cleared.
- Dispatch:
  - disp_ready_rs0 = |FREE & ~flush & ~reset.
  - e_alloc_rs0 = one-hot of the lowest-index FREE entry, gated by disp_valid_rs0 & disp_ready_rs0. It is combinational and 0 whenever reset or flush is high.
  - An entry freed by issue in cycle N is not allocatable until N+1.
  - The robid is stored per entry on alloc.
- Eligibility: eligible[i] = (state == VALID) & e_srcs_ready_rs1[i].
  - The alloc cycle is never eligible, because the entry is still FREE.
  - An entry with sources ready at dispatch is therefore first eligible the cycle after alloc.
  - Minimum dispatch-to-iss_valid latency is 2 cycles.
- Pick:
  - Enabled when ~iss_valid_rs1 | iss_ready_rs1, i.e. the slot is empty or draining this cycle.
  - Selects one eligible entry and registers iss_valid_rs1/iss_entry_rs1/iss_robid_rs1.
  - Back-to-back issue at 1 per cycle is supported.
- Stall: while iss_valid_rs1 & ~iss_ready_rs1:
  - the outputs hold stable;
  - no new pick is made;
  - the ISSUING entry is not reallocated.
- Flush:
  - iss_valid_rs1 = 0 next cycle;
  - any handshake in the flush cycle is ignored for state purposes (the entry becomes FREE regardless);
  - the dispatch offered in the flush cycle is refused.
- num_free:
  - registered next count = count − alloc + free-on-issue;
  - it is NUM_ENTRIES after a flush;
  - it never underflows or overflows; flag any violation with an assertion.
- Assertions:
  - e_alloc_rs0 is one-hot0;
  - at most one entry is ISSUING;
  - iss_valid_rs1 ↔ exactly one ISSUING entry (except in the cycle after flush).

Optional Feature:
- Macro: RS_SCHED_AGE_PICK_EN.
- Defined:
  - An NUM_ENTRIES×NUM_ENTRIES age matrix is kept. age[j][i] = 1 means j is older than i.
  - On alloc of i: set age[j][i] = 1 for all j not FREE, and clear row i.
  - Pick the eligible i with no eligible j where age[j][i] = 1, giving oldest-first issue.
- Undefined:
  - Fixed priority, lowest-index eligible entry wins.
  - No age storage is built.

Decomposition:
- rob_defs / common package additions:
  - t_rs_ent_st enum (RS_FREE, RS_VALID, RS_ISSUING);
  - t_rs_sched_iss struct {robid, entry}.
- One sub-module, rs_sched_pick:
  - inputs: eligible vector plus (optionally) the age matrix;
  - output: one-hot pick plus valid;
  - reused by future RS instances.

Test Plan:
- Reset then idle → disp_ready_rs0 = 1, num_free = 8, iss_valid_rs1 = 0.
- Dispatch robid 5 with e_srcs_ready_rs1[0] = 1 from the next cycle, iss_ready_rs1 = 1 → e_alloc_rs0 = 8'b1 at cycle 0, iss_valid_rs1 with entry 0 / robid 5 at cycle 2, num_free back to 8 at cycle 3.
- Fill all 8 entries with srcs not ready → disp_ready_rs0 = 0 and num_free = 0. Raise ready on entry 6 → it issues; the next dispatch lands in entry 6.
- Entries 2 then 0 allocated, both ready together:
  - with RS_SCHED_AGE_PICK_EN, entry 2 issues first;
  - without it, entry 0 issues first.
- Hold iss_ready_rs1 = 0 for 4 cycles with 3 ready entries → iss_entry/robid stable, no state change. Release → 3 consecutive issues on 3 cycles.
- Flush while 5 entries are valid, one ISSUING, and disp_valid_rs0 = 1 → no alloc, iss_valid_rs1 = 0 and num_free = 8 next cycle.

Source files
------------

// File: rtl/rs_sched_pkg.sv
// Shared types for the reservation-station scheduler: entry state, robid and
// the registered issue-slot payload.
package rs_sched_pkg;

   localparam int ROB_ID_W       = 6;
   localparam int RS_NUM_ENTRIES = 8;
   localparam int RS_IDX_W       = $clog2(RS_NUM_ENTRIES);

   typedef logic [ROB_ID_W-1:0] t_rob_id;

   typedef enum logic [1:0] {
      RS_FREE,
      RS_VALID,
      RS_ISSUING
   } t_rs_ent_st;

   typedef struct packed {
      t_rob_id               robid;
      logic [RS_IDX_W-1:0]   entry;
   } t_rs_sched_iss;

endpackage

// File: rtl/rs_sched_pick.sv
// One-of-N picker over an eligible vector: oldest-first via an age matrix when
// AGE_EN is set, otherwise fixed lowest-index priority.
module rs_sched_pick #(
   parameter int N      = 8,
   parameter bit AGE_EN = 1'b0
) (
   input  logic [N-1:0]        elig_i,
   input  logic [N-1:0][N-1:0] age_i,
   output logic [N-1:0]        pick_oh_o,
   output logic                pick_vld_o
);

   logic [N-1:0] cand;

   generate
      if (AGE_EN) begin : g_age
         // age_i[j][i] = 1 means j is older than i; drop i if any older j is eligible
         always_comb begin
            cand = elig_i;
            for (int i = 0; i < N; i++) begin
               for (int j = 0; j < N; j++) begin
                  if (elig_i[j] && age_i[j][i]) cand[i] = 1'b0;
               end
            end
         end
      end else begin : g_fixed
         logic unused_age;
         assign unused_age = ^age_i;
         assign cand       = elig_i;
      end
   endgenerate

   // lowest set bit also keeps the output one-hot if the age state ever ties
   assign pick_oh_o  = cand & (~cand + N'(1));
   assign pick_vld_o = |cand;

endmodule

// File: rtl/rs_sched.sv
// Reservation-station scheduler: entry allocation, ready pick and a registered
// valid/ready issue port. Define RS_SCHED_AGE_PICK_EN for oldest-first pick.
module rs_sched
   import rs_sched_pkg::*;
#(
   parameter int NUM_ENTRIES = RS_NUM_ENTRIES,
   parameter int IDX_W       = $clog2(NUM_ENTRIES),
   parameter int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   disp_valid_rs0,
   input  t_rob_id                disp_robid_rs0,
   output logic                   disp_ready_rs0,
   output logic [NUM_ENTRIES-1:0] e_alloc_rs0,
   input  logic [NUM_ENTRIES-1:0] e_srcs_ready_rs1,
   output logic                   iss_valid_rs1,
   output logic [IDX_W-1:0]       iss_entry_rs1,
   output t_rob_id                iss_robid_rs1,
   input  logic                   iss_ready_rs1,
   input  logic                   flush,
   output logic [CNT_W-1:0]       num_free
);

   t_rs_ent_st st_q [NUM_ENTRIES];
   t_rs_ent_st st_d [NUM_ENTRIES];
   t_rob_id    rob_q [NUM_ENTRIES];

   logic [NUM_ENTRIES-1:0] free_vec, valid_vec, issuing_vec, eligible;
   logic [NUM_ENTRIES-1:0] pick_oh;
   logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] age;
   logic [IDX_W-1:0]       pick_idx;
   logic                   pick_vld, pick_en, pick_fire, iss_fire, alloc;

   logic                   iss_valid_q, iss_valid_d;
   t_rs_sched_iss          iss_q, iss_d;
   logic [CNT_W-1:0]       num_free_q, num_free_d;

   // ---------------- dispatch / alloc ----------------
   assign disp_ready_rs0 = (|free_vec) & ~flush & ~reset;
   assign e_alloc_rs0    = (free_vec & (~free_vec + NUM_ENTRIES'(1)))
                           & {NUM_ENTRIES{disp_valid_rs0 & disp_ready_rs0}};
   assign alloc          = |e_alloc_rs0;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_ENTRIES; i++) rob_q[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_ENTRIES; i++)
            if (e_alloc_rs0[i]) rob_q[i] <= disp_robid_rs0;
      end
   end

   // ---------------- per-entry FSM ----------------
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_ENTRIES; i++) st_q[i] <= RS_FREE;
      end else begin
         st_q <= st_d;
      end
   end

   assign iss_fire  = iss_valid_q & iss_ready_rs1;
   assign pick_en   = (~iss_valid_q | iss_ready_rs1) & ~flush;
   assign pick_fire = pick_en & pick_vld;

   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         st_d[i] = st_q[i];
         case (st_q[i])
            RS_FREE:    if (e_alloc_rs0[i])              st_d[i] = RS_VALID;
            RS_VALID:   if (pick_fire && pick_oh[i])     st_d[i] = RS_ISSUING;
            RS_ISSUING: if (iss_fire)                    st_d[i] = RS_FREE;
            default:                                     st_d[i] = RS_FREE;
         endcase
         if (flush) st_d[i] = RS_FREE;
      end
   end

   always_comb begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         free_vec[i]    = (st_q[i] == RS_FREE);
         valid_vec[i]   = (st_q[i] == RS_VALID);
         issuing_vec[i] = (st_q[i] == RS_ISSUING);
      end
   end

   assign eligible = valid_vec & e_srcs_ready_rs1;

   // ---------------- age tracking ----------------
`ifdef RS_SCHED_AGE_PICK_EN
   localparam bit AGE_EN = 1'b1;
   logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] age_q, age_d;

   always_comb begin
      age_d = age_q;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
         if (e_alloc_rs0[i]) begin
            age_d[i] = '0;
            for (int j = 0; j < NUM_ENTRIES; j++)
               if (!free_vec[j]) age_d[j][i] = 1'b1;
         end
      end
      if (flush) age_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) age_q <= '0;
      else       age_q <= age_d;
   end

   assign age = age_q;
`else
   localparam bit AGE_EN = 1'b0;
   assign age = '0;
`endif

   rs_sched_pick #(
      .N      (NUM_ENTRIES),
      .AGE_EN (AGE_EN)
   ) u_pick (
      .elig_i     (eligible),
      .age_i      (age),
      .pick_oh_o  (pick_oh),
      .pick_vld_o (pick_vld)
   );

   always_comb begin
      pick_idx = '0;
      for (int i = 0; i < NUM_ENTRIES; i++)
         if (pick_oh[i]) pick_idx = IDX_W'(i);
   end

   // ---------------- issue slot ----------------
   always_comb begin
      iss_valid_d = iss_valid_q;
      iss_d       = iss_q;
      if (flush) begin
         iss_valid_d = 1'b0;
      end else if (pick_en) begin
         iss_valid_d = pick_vld;
         if (pick_vld) begin
            iss_d.entry = RS_IDX_W'(pick_idx);
            iss_d.robid = rob_q[pick_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         iss_valid_q <= 1'b0;
         iss_q       <= '0;
      end else begin
         iss_valid_q <= iss_valid_d;
         iss_q       <= iss_d;
      end
   end

   assign iss_valid_rs1 = iss_valid_q;
   assign iss_entry_rs1 = IDX_W'(iss_q.entry);
   assign iss_robid_rs1 = iss_q.robid;

   // ---------------- free count ----------------
   always_comb begin
      if (flush) num_free_d = CNT_W'(NUM_ENTRIES);
      else       num_free_d = num_free_q + CNT_W'(iss_fire) - CNT_W'(alloc);
   end

   always_ff @(posedge clk) begin
      if (reset) num_free_q <= CNT_W'(NUM_ENTRIES);
      else       num_free_q <= num_free_d;
   end

   assign num_free = num_free_q;

   // ---------------- invariants ----------------
   a_alloc_onehot0: assert property (@(posedge clk) disable iff (reset)
      $onehot0(e_alloc_rs0));
   a_one_issuing: assert property (@(posedge clk) disable iff (reset)
      $countones(issuing_vec) <= 1);
   a_iss_matches_state: assert property (@(posedge clk) disable iff (reset)
      iss_valid_q == ($countones(issuing_vec) == 1));
   a_free_no_underflow: assert property (@(posedge clk) disable iff (reset || flush)
      !(num_free_q == '0 && alloc && !iss_fire));
   a_free_no_overflow: assert property (@(posedge clk) disable iff (reset || flush)
      !(num_free_q == CNT_W'(NUM_ENTRIES) && iss_fire && !alloc));

endmodule

// File: tb/tb_rs_sched.sv
// Directed bench for rs_sched: reset, single issue, fill/reuse, pick order,
// issue stall and flush, each with hand-computed expectations.
module tb_rs_sched;
   import rs_sched_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       disp_valid_rs0;
   t_rob_id    disp_robid_rs0;
   logic       disp_ready_rs0;
   logic [7:0] e_alloc_rs0;
   logic [7:0] e_srcs_ready_rs1;
   logic       iss_valid_rs1;
   logic [2:0] iss_entry_rs1;
   t_rob_id    iss_robid_rs1;
   logic       iss_ready_rs1;
   logic       flush;
   logic [3:0] num_free;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   rs_sched dut (
      .clk              (clk),
      .reset            (reset),
      .disp_valid_rs0   (disp_valid_rs0),
      .disp_robid_rs0   (disp_robid_rs0),
      .disp_ready_rs0   (disp_ready_rs0),
      .e_alloc_rs0      (e_alloc_rs0),
      .e_srcs_ready_rs1 (e_srcs_ready_rs1),
      .iss_valid_rs1    (iss_valid_rs1),
      .iss_entry_rs1    (iss_entry_rs1),
      .iss_robid_rs1    (iss_robid_rs1),
      .iss_ready_rs1    (iss_ready_rs1),
      .flush            (flush),
      .num_free         (num_free)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; disp_valid_rs0 = 1'b1; disp_robid_rs0 = 6'd1;
      e_srcs_ready_rs1 = '0; iss_ready_rs1 = 1'b1; flush = 1'b0;
      tick();
      #1;
      n_tests++; if (disp_ready_rs0 !== 1'b0) begin n_fail++; $display("FAIL rst_disp_ready got %0h want 0", disp_ready_rs0); end
      n_tests++; if (e_alloc_rs0 !== 8'h00) begin n_fail++; $display("FAIL rst_alloc got %0h want 0", e_alloc_rs0); end
      tick();
      reset = 1'b0; disp_valid_rs0 = 1'b0;
      #1;
      n_tests++; if (disp_ready_rs0 !== 1'b1) begin n_fail++; $display("FAIL idle_disp_ready got %0h want 1", disp_ready_rs0); end
      n_tests++; if (num_free !== 4'd8) begin n_fail++; $display("FAIL idle_num_free got %0d want 8", num_free); end
      n_tests++; if (iss_valid_rs1 !== 1'b0) begin n_fail++; $display("FAIL idle_iss_valid got %0h want 0", iss_valid_rs1); end
      n_tests++; if (iss_entry_rs1 !== 3'd0 || iss_robid_rs1 !== 6'd0) begin n_fail++; $display("FAIL idle_iss_payload got %0d/%0d want 0/0", iss_entry_rs1, iss_robid_rs1); end
   endtask

   task automatic test_single();
      // cycle 0: dispatch robid 5
      disp_valid_rs0 = 1'b1; disp_robid_rs0 = 6'd5; iss_ready_rs1 = 1'b1;
      #1;
      n_tests++; if (e_alloc_rs0 !== 8'h01) begin n_fail++; $display("FAIL single_alloc got %0h want 01", e_alloc_rs0); end
      tick();
      // cycle 1: sources ready, not yet visible on the issue port
      disp_valid_rs0 = 1'b0; e_srcs_ready_rs1 = 8'h01;
      n_tests++; if (iss_valid_rs1 !== 1'b0 || num_free !== 4'd7) begin n_fail++; $display("FAIL single_c1 got v=%0h nf=%0d want v=0 nf=7", iss_valid_rs1, num_free); end
      tick();
      // cycle 2: issue slot valid
      n_tests++; if (iss_valid_rs1 !== 1'b1 || iss_entry_rs1 !== 3'd0 || iss_robid_rs1 !== 6'd5) begin n_fail++; $display("FAIL single_issue got v=%0h e=%0d r=%0d want 1/0/5", iss_valid_rs1, iss_entry_rs1, iss_robid_rs1); end
      e_srcs_ready_rs1 = '0;
      tick();
      n_tests++; if (iss_valid_rs1 !== 1'b0 || num_free !== 4'd8) begin n_fail++; $display("FAIL single_c3 got v=%0h nf=%0d want v=0 nf=8", iss_valid_rs1, num_free); end
   endtask

   task automatic test_fill();
      logic [7:0] exp_oh;
      for (int k = 0; k < 8; k++) begin
         disp_valid_rs0 = 1'b1; disp_robid_rs0 = 6'(10 + k);
         exp_oh = 8'h01 << k;
         #1;
         n_tests++; if (e_alloc_rs0 !== exp_oh) begin n_fail++; $display("FAIL fill_alloc%0d got %0h want %0h", k, e_alloc_rs0, exp_oh); end
         tick();
      end
      disp_valid_rs0 = 1'b0;
      #1;
      n_tests++; if (disp_ready_rs0 !== 1'b0 || num_free !== 4'd0) begin n_fail++; $display("FAIL fill_full got rdy=%0h nf=%0d want 0/0", disp_ready_rs0, num_free); end
      e_srcs_ready_rs1 = 8'h40;
      tick();
      e_srcs_ready_rs1 = '0; disp_valid_rs0 = 1'b1; disp_robid_rs0 = 6'd40;
      #1;
      n_tests++; if (iss_valid_rs1 !== 1'b1 || iss_entry_rs1 !== 3'd6 || iss_robid_rs1 !== 6'd16) begin n_fail++; $display("FAIL fill_issue6 got v=%0h e=%0d r=%0d want 1/6/16", iss_valid_rs1, iss_entry_rs1, iss_robid_rs1); end
      // entry 6 is handshaking this cycle and must not be reallocated yet
      n_tests++; if (disp_ready_rs0 !== 1'b0 || e_alloc_rs0 !== 8'h00) begin n_fail++; $display("FAIL fill_noreuse got rdy=%0h al=%0h want 0/00", disp_ready_rs0, e_alloc_rs0); end
      tick();
      n_tests++; if (disp_ready_rs0 !== 1'b1 || e_alloc_rs0 !== 8'h40 || num_free !== 4'd1) begin n_fail++; $display("FAIL fill_reuse6 got rdy=%0h al=%0h nf=%0d want 1/40/1", disp_ready_rs0, e_alloc_rs0, num_free); end
      tick();
      disp_valid_rs0 = 1'b0;
      n_tests++; if (num_free !== 4'd0) begin n_fail++; $display("FAIL fill_refull got %0d want 0", num_free); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_tests++; if (num_free !== 4'd8 || iss_valid_rs1 !== 1'b0) begin n_fail++; $display("FAIL fill_flush got nf=%0d v=%0h want 8/0", num_free, iss_valid_rs1); end
   endtask

   task automatic test_pick_order();
      logic [2:0] e_first, e_second;
      t_rob_id    r_first, r_second;
`ifdef RS_SCHED_AGE_PICK_EN
      e_first = 3'd2; r_first = 6'd22; e_second = 3'd0; r_second = 6'd23;
`else
      e_first = 3'd0; r_first = 6'd23; e_second = 3'd2; r_second = 6'd22;
`endif
      iss_ready_rs1 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         disp_valid_rs0 = 1'b1; disp_robid_rs0 = 6'(20 + k);
         tick();
      end
      disp_valid_rs0 = 1'b0; e_srcs_ready_rs1 = 8'h03;
      tick();
      n_tests++; if (iss_valid_rs1 !== 1'b1 || iss_entry_rs1 !== 3'd0 || iss_robid_rs1 !== 6'd20) begin n_fail++; $display("FAIL order_e0 got v=%0h e=%0d r=%0d want 1/0/20", iss_valid_rs1, iss_entry_rs1, iss_robid_rs1); end
      tick();
      n_tests++; if (iss_valid_rs1 !== 1'b1 || iss_entry_rs1 !== 3'd1 || iss_robid_rs1 !== 6'd21) begin n_fail++; $display("FAIL order_e1 got v=%0h e=%0d r=%0d want 1/1/21", iss_valid_rs1, iss_entry_rs1, iss_robid_rs1); end
      e_srcs_ready_rs1 = '0; disp_valid_rs0 = 1'b1; disp_robid_rs0 = 6'd23;
      #1;
      n_tests++; if (e_alloc_rs0 !== 8'h01) begin n_fail++; $display("FAIL order_realloc0 got %0h want 01", e_alloc_rs0); end
      tick();
      disp_valid_rs0 = 1'b0; e_srcs_ready_rs1 = 8'h05;
      n_tests++; if (iss_valid_rs1 !== 1'b0) begin n_fail++; $display("FAIL order_gap got %0h want 0", iss_valid_rs1); end
      tick();
      n_tests++; if (iss_entry_rs1 !== e_first || iss_robid_rs1 !== r_first) begin n_fail++; $display("FAIL order_first got e=%0d r=%0d want %0d/%0d", iss_entry_rs1, iss_robid_rs1, e_first, r_first); end
      tick();
      n_tests++; if (iss_valid_rs1 !== 1'b1 || iss_entry_rs1 !== e_second || iss_robid_rs1 !== r_second) begin n_fail++; $display("FAIL order_second got v=%0h e=%0d r=%0d want 1/%0d/%0d", iss_valid_rs1, iss_entry_rs1, iss_robid_rs1, e_second, r_second); end
      e_srcs_ready_rs1 = '0;
      tick();
      n_tests++; if (iss_valid_rs1 !== 1'b0 || num_free !== 4'd8) begin n_fail++; $display("FAIL order_drain got v=%0h nf=%0d want 0/8", iss_valid_rs1, num_free); end
   endtask

   task automatic test_back_to_back();
      iss_ready_rs1 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         disp_valid_rs0 = 1'b1; disp_robid_rs0 = 6'(30 + k);
         tick();
      end
      disp_valid_rs0 = 1'b0; iss_ready_rs1 = 1'b0; e_srcs_ready_rs1 = 8'h07;
      tick();
      for (int k = 0; k < 4; k++) begin
         n_tests++; if (iss_valid_rs1 !== 1'b1 || iss_entry_rs1 !== 3'd0 || iss_robid_rs1 !== 6'd30 || num_free !== 4'd5) begin n_fail++; $display("FAIL stall%0d got v=%0h e=%0d r=%0d nf=%0d want 1/0/30/5", k, iss_valid_rs1, iss_entry_rs1, iss_robid_rs1, num_free); end
         tick();
      end
      iss_ready_rs1 = 1'b1;
      n_tests++; if (iss_entry_rs1 !== 3'd0 || iss_robid_rs1 !== 6'd30) begin n_fail++; $display("FAIL b2b_0 got e=%0d r=%0d want 0/30", iss_entry_rs1, iss_robid_rs1); end
      tick();
      n_tests++; if (iss_valid_rs1 !== 1'b1 || iss_entry_rs1 !== 3'd1 || iss_robid_rs1 !== 6'd31) begin n_fail++; $display("FAIL b2b_1 got v=%0h e=%0d r=%0d want 1/1/31", iss_valid_rs1, iss_entry_rs1, iss_robid_rs1); end
      tick();
      n_tests++; if (iss_valid_rs1 !== 1'b1 || iss_entry_rs1 !== 3'd2 || iss_robid_rs1 !== 6'd32) begin n_fail++; $display("FAIL b2b_2 got v=%0h e=%0d r=%0d want 1/2/32", iss_valid_rs1, iss_entry_rs1, iss_robid_rs1); end
      e_srcs_ready_rs1 = '0;
      tick();
      n_tests++; if (iss_valid_rs1 !== 1'b0 || num_free !== 4'd8) begin n_fail++; $display("FAIL b2b_drain got v=%0h nf=%0d want 0/8", iss_valid_rs1, num_free); end
   endtask

   task automatic test_flush();
      iss_ready_rs1 = 1'b1;
      for (int k = 0; k < 5; k++) begin
         disp_valid_rs0 = 1'b1; disp_robid_rs0 = 6'(50 + k);
         tick();
      end
      disp_valid_rs0 = 1'b0; iss_ready_rs1 = 1'b0; e_srcs_ready_rs1 = 8'h01;
      tick();
      n_tests++; if (iss_valid_rs1 !== 1'b1 || iss_robid_rs1 !== 6'd50 || num_free !== 4'd3) begin n_fail++; $display("FAIL flush_pre got v=%0h r=%0d nf=%0d want 1/50/3", iss_valid_rs1, iss_robid_rs1, num_free); end
      flush = 1'b1; disp_valid_rs0 = 1'b1; disp_robid_rs0 = 6'd60; iss_ready_rs1 = 1'b1;
      #1;
      n_tests++; if (e_alloc_rs0 !== 8'h00 || disp_ready_rs0 !== 1'b0) begin n_fail++; $display("FAIL flush_refuse got al=%0h rdy=%0h want 00/0", e_alloc_rs0, disp_ready_rs0); end
      tick();
      flush = 1'b0; disp_valid_rs0 = 1'b0; e_srcs_ready_rs1 = '0;
      n_tests++; if (iss_valid_rs1 !== 1'b0 || num_free !== 4'd8) begin n_fail++; $display("FAIL flush_post got v=%0h nf=%0d want 0/8", iss_valid_rs1, num_free); end
      disp_valid_rs0 = 1'b1; disp_robid_rs0 = 6'd61;
      #1;
      n_tests++; if (e_alloc_rs0 !== 8'h01) begin n_fail++; $display("FAIL flush_realloc got %0h want 01", e_alloc_rs0); end
      tick();
      disp_valid_rs0 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single();
      test_fill();
      test_pick_order();
      test_back_to_back();
      test_flush();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
